fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Single-clock synchronous FIFO, WIDTH-bit data, DEPTH entries.
- Registered read data with a one-cycle `valid` strobe.
- Occupancy count, full/empty and almost-full/almost-empty flags, plus one-cycle overflow/underflow error strobes.
- Generic buffering element between producer and consumer logic in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, number of storage entries; must be a power of two, ≥ 4.
- ADDR_WIDTH, 8, width parameter for the count port (count is ADDR_WIDTH+1 bits); must satisfy ADDR_WIDTH ≥ log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- data_in  input  WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_out  output  WIDTH  registered read data
- empty  output  1  count == 0
- almost_empty  output  1  count == 1
- full  output  1  count == DEPTH
- almost_full  output  1  count == DEPTH-1
- valid  output  1  data_out updated by an accepted read in the previous edge
- overflow  output  1  write rejected because FIFO full
- underflow  output  1  read rejected because FIFO empty
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: rst_n low asynchronously clears write pointer, read pointer, count, data_out, valid, overflow and underflow to 0.
  - Flags follow from count: empty=1, almost_empty=0, full=0, almost_full=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted on a rising edge when wr_en=1 and full=0.
  - mem[wptr] <= data_in; wptr increments.
- Read accepted on a rising edge when rd_en=1 and empty=0.
  - data_out <= mem[rptr]; rptr increments; valid <= 1.
  - Otherwise valid <= 0 and data_out holds its value.
- Read latency: data appears on data_out one edge after the accepted read edge, coincident with valid=1.
- Count update per edge:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr_en and rd_en:
  - Each is qualified independently against the pre-edge flags.
  - When full: only the read is accepted and the write is rejected (overflow).
  - When empty: only the write is accepted and the read is rejected (underflow).
  - Otherwise both are accepted.
- overflow is registered: set for exactly one cycle after any edge where wr_en=1 and full=1, else 0. Contents are unchanged by a rejected write.
- underflow is registered: set for exactly one cycle after any edge where rd_en=1 and empty=1, else 0. data_out is unchanged by a rejected read.
- Flags are combinational decodes of the count register; no glitch-free requirement beyond the register outputs.
- Data ordering is strictly first-in first-out across wrap-around.

Decomposition:
- No shared package required; WIDTH/DEPTH/ADDR_WIDTH are module parameters.
- A derived local constant PTR_W = $clog2(DEPTH) lives inside the module.
- One natural sub-module: fifo_mem, a simple dual-port register array.
  - One write port (we, waddr, wdata).
  - One synchronous read port (re, raddr, rdata registered).
  - Pointer/count/flag control stays in the top.

Test Plan:
- Reset: drive rst_n=0 at t=0 -> empty=1, full=0, count=0, valid=0, data_out=0, overflow=underflow=0, asynchronously, without a clock edge.
- Fill: after reset, write 1..32 on 32 consecutive edges.
  - count steps 1..32.
  - almost_empty=1 only at count=1.
  - almost_full=1 at count=31.
  - full=1 at count=32; empty=0 throughout.
- Overflow: with FIFO full, hold wr_en=1 with data_in=99 for one edge -> overflow=1 for one cycle, count stays 32, contents unchanged.
- Drain: rd_en=1 for 32 edges -> data_out sequence 1,2,...,32, each with valid=1 one edge after its read; count decrements to 0; empty=1 at end.
- Underflow: with FIFO empty, rd_en=1 for one edge -> underflow=1 for one cycle, valid=0, data_out stays 32, count stays 0.
- Wrap and simultaneity, each step starting from a known occupancy:
  - Write 20, read 20, then write 16 values 100..115 (pointers wrap).
  - Then wr_en=rd_en=1 for 10 edges -> count constant at 16, reads return 100..109 in order.
  - Assert rst_n=0 mid-stream -> all outputs return to reset values at once.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO slice; the modules take these as parameter defaults.
package fifo_pkg;
  localparam int FIFO_WIDTH_DFLT      = 8;
  localparam int FIFO_DEPTH_DFLT      = 32;
  localparam int FIFO_ADDR_WIDTH_DFLT = 8;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DFLT,
  parameter int DEPTH = FIFO_DEPTH_DFLT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read; holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointer, occupancy and flag control around fifo_mem.
// Writes and reads are each qualified against the pre-edge full/empty flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DFLT,
  parameter int DEPTH      = FIFO_DEPTH_DFLT,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  valid,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_full;
  logic             w_empty;

  // Flags decode straight from the count register.
  assign w_full       = (r_count == C_FULL);
  assign w_empty      = (r_count == '0);
  assign w_wr_acc     = wr_en & ~w_full;
  assign w_rd_acc     = rd_en & ~w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count == C_AFULL);
  assign almost_empty = (r_count == C_ONE);
  assign count        = r_count;
  assign valid        = r_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + P_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + P_ONE;
    end
  end

  // Occupancy: net change of accepted writes minus accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle strobes: read-data valid and rejected-request errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid     <= w_rd_acc;
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_wr_acc),
    .waddr (r_wptr),
    .wdata (data_in),
    .re    (w_rd_acc),
    .raddr (r_rptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed steps plus a randomized phase,
// all checked against a queue-based reference model.
module tb_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 32;
  localparam int ADDR_WIDTH = 8;

  logic                clk;
  logic                rst_n;
  logic [WIDTH-1:0]    data_in;
  logic                wr_en;
  logic                rd_en;
  logic [WIDTH-1:0]    data_out;
  logic                empty;
  logic                almost_empty;
  logic                full;
  logic                almost_full;
  logic                valid;
  logic                overflow;
  logic                underflow;
  logic [ADDR_WIDTH:0] count;

  fifo #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .almost_full  (almost_full),
    .valid        (valid),
    .overflow     (overflow),
    .underflow    (underflow),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_valid;
  logic             exp_ovf;
  logic             exp_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // One clock edge of the FIFO rules, applied to the pre-edge occupancy.
  task automatic model_step(input logic wr, input logic rd, input logic [WIDTH-1:0] din);
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    exp_ovf   = wr && was_full;
    exp_unf   = rd && was_empty;
    exp_valid = 1'b0;
    if (rd && !was_empty) begin
      exp_dout  = mq.pop_front();
      exp_valid = 1'b1;
    end
    if (wr && !was_full) mq.push_back(din);
  endtask

  task automatic check_all(input string ph);
    int n;
    n = mq.size();
    chk({ph, ".count"},        32'(count),        32'(n));
    chk({ph, ".empty"},        32'(empty),        32'(n == 0));
    chk({ph, ".almost_empty"}, 32'(almost_empty), 32'(n == 1));
    chk({ph, ".full"},         32'(full),         32'(n == DEPTH));
    chk({ph, ".almost_full"},  32'(almost_full),  32'(n == DEPTH - 1));
    chk({ph, ".valid"},        32'(valid),        32'(exp_valid));
    chk({ph, ".overflow"},     32'(overflow),     32'(exp_ovf));
    chk({ph, ".underflow"},    32'(underflow),    32'(exp_unf));
    chk({ph, ".data_out"},     32'(data_out),     32'(exp_dout));
  endtask

  // Drive one cycle's request, let the edge happen, then check 1 time unit later.
  task automatic cycle(input string ph, input logic wr, input logic rd, input logic [WIDTH-1:0] din);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    model_step(wr, rd, din);
    #1;
    check_all(ph);
  endtask

  initial begin
    int bias_wr;
    int bias_rd;

    // Asynchronous reset at time 0, checked before any clock edge.
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;

    // Fill 1..32
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
    chk("fill_final_count", 32'(count), 32'(DEPTH));
    chk("fill_final_full",  32'(full),  32'd1);

    // Overflow attempt with value 99
    cycle("ovf", 1'b1, 1'b0, 8'd99);
    chk("ovf_strobe", 32'(overflow), 32'd1);
    cycle("ovf_idle", 1'b0, 1'b0, 8'd0);

    // Drain: expect 1..32 in order
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("drain", 1'b0, 1'b1, 8'd0);
      chk("drain_seq", 32'(data_out), 32'(i));
    end
    cycle("drain_idle", 1'b0, 1'b0, 8'd0);

    // Underflow: data_out holds 32
    cycle("unf", 1'b0, 1'b1, 8'd0);
    chk("unf_dout_hold", 32'(data_out), 32'd32);
    cycle("unf_idle", 1'b0, 1'b0, 8'd0);

    // Wrap: write 20 random, read 20, write 100..115
    for (int i = 0; i < 20; i++) cycle("wrap_wr", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) cycle("wrap_rd", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 16; i++) cycle("wrap_wr2", 1'b1, 1'b0, 8'(100 + i));

    // Simultaneous read+write: count stays 16, reads return 100..109
    for (int i = 0; i < 10; i++) begin
      cycle("simul", 1'b1, 1'b1, 8'($urandom));
      chk("simul_count", 32'(count), 32'd16);
      chk("simul_seq", 32'(data_out), 32'(100 + i));
    end

    // Simultaneous requests at the boundaries: full and empty
    while (mq.size() < DEPTH) cycle("to_full", 1'b1, 1'b0, 8'($urandom));
    cycle("simul_full", 1'b1, 1'b1, 8'($urandom));
    while (mq.size() > 0) cycle("to_empty", 1'b0, 1'b1, 8'd0);
    cycle("simul_empty", 1'b1, 1'b1, 8'($urandom));

    // Randomized traffic with alternating bias to visit full and empty
    for (int seg = 0; seg < 6; seg++) begin
      bias_wr = (seg % 2 == 0) ? 80 : 25;
      bias_rd = (seg % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 120; i++) begin
        cycle("rand", ($urandom_range(0, 99) < bias_wr), ($urandom_range(0, 99) < bias_rd),
              8'($urandom));
      end
    end

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b1, 8'($urandom));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b1;

    // Operates normally after reset
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 1'b0, 8'(200 + i));
    for (int i = 0; i < 5; i++) cycle("post_rst_rd", 1'b0, 1'b1, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
